// File: rtl/arb_pkg.sv
// Shared arbitration constants for rr_idx_arbiter and its priority search.
package arb_pkg;

   localparam int ARB_MODE_FIXED = 0;
   localparam int ARB_MODE_RR    = 1;

endpackage

// File: rtl/prio_find.sv
// Wrapped first-set search: lowest set bit of req at or above start, wrapping N-1 -> 0.
module prio_find #(
   parameter int N = 16,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] start,
   output logic          found,
   output logic [PW-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Scan from the farthest offset down so the nearest set bit is written last.
      for (int i = N - 1; i >= 0; i--) begin
         logic [PW:0] pos;
         pos = {1'b0, start} + (PW + 1)'(i);
         if (pos >= (PW + 1)'(N)) begin
            pos = pos - (PW + 1)'(N);
         end
         if (req[pos[PW-1:0]]) begin
            found = 1'b1;
            idx   = pos[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_idx_arbiter.sv
// N-way fixed/round-robin index arbiter with a registered valid/ready grant.
// Optional grant locking is enabled by defining RR_IDX_ARBITER_LOCK_EN.
module rr_idx_arbiter
   import arb_pkg::*;
#(
   parameter int N = 16,
   parameter int MODE = ARB_MODE_RR,
   localparam int IDX_W = $clog2(N) + 1,
   localparam int PTR_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
`ifdef RR_IDX_ARBITER_LOCK_EN
   input  logic             lock,
`endif
   input  logic             gnt_ready,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx,
   output logic [N-1:0]     gnt_onehot,
   output logic [PTR_W-1:0] ptr
);

   logic             accept;
   logic             load;
   logic             lock_hit;
   logic             found;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] start;
   logic [PTR_W-1:0] win_idx;
   logic [N-1:0]     win_onehot;

   assign accept  = gnt_valid & gnt_ready;
   assign load    = ~gnt_valid | accept;
   assign ptr_inc = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx[PTR_W-1:0] + 1'b1;

`ifdef RR_IDX_ARBITER_LOCK_EN
   assign lock_hit = accept & lock & req[gnt_idx[PTR_W-1:0]];
`else
   assign lock_hit = 1'b0;
`endif

   generate
      if (MODE == ARB_MODE_RR) begin : g_rr_start
         // The search must already see the post-accept start on the accept edge.
         assign start = accept ? ptr_inc : ptr;
      end else begin : g_fixed_start
         assign start = '0;
      end
   endgenerate

   prio_find #(.N(N)) u_prio_find (
      .req   (req),
      .start (start),
      .found (found),
      .idx   (win_idx)
   );

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_onehot
         assign win_onehot[gi] = (win_idx == PTR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_valid  <= 1'b0;
         gnt_idx    <= IDX_W'(N);
         gnt_onehot <= '0;
         ptr        <= '0;
      end else begin
         if (accept && !lock_hit) begin
            ptr <= ptr_inc;
         end
         // A lock hit simply keeps the current grant registers.
         if (load && !lock_hit) begin
            if (found) begin
               gnt_valid  <= 1'b1;
               gnt_idx    <= {1'b0, win_idx};
               gnt_onehot <= win_onehot;
            end else begin
               gnt_valid  <= 1'b0;
               gnt_idx    <= IDX_W'(N);
               gnt_onehot <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rr_idx_arbiter.sv
// Scoreboard bench for rr_idx_arbiter: one round-robin and one fixed-priority instance.
module tb_rr_idx_arbiter;

   localparam int N  = 16;
   localparam int IW = 5;
   localparam int PW = 4;

   typedef struct packed {
      logic          v;
      logic [IW-1:0] idx;
      logic [N-1:0]  oh;
      logic [PW-1:0] ptr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          gnt_ready = 1'b0;
   logic          lock = 1'b0;
   logic [N-1:0]  req = '0;

   logic          rr_valid, fx_valid;
   logic [IW-1:0] rr_idx, fx_idx;
   logic [N-1:0]  rr_onehot, fx_onehot;
   logic [PW-1:0] rr_ptr, fx_ptr;

   exp_t q_rr[$];
   exp_t q_fx[$];
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   rr_idx_arbiter #(.N(N), .MODE(1)) dut_rr (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
`ifdef RR_IDX_ARBITER_LOCK_EN
      .lock       (lock),
`endif
      .gnt_ready  (gnt_ready),
      .gnt_valid  (rr_valid),
      .gnt_idx    (rr_idx),
      .gnt_onehot (rr_onehot),
      .ptr        (rr_ptr)
   );

   rr_idx_arbiter #(.N(N), .MODE(0)) dut_fx (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
`ifdef RR_IDX_ARBITER_LOCK_EN
      .lock       (lock),
`endif
      .gnt_ready  (gnt_ready),
      .gnt_valid  (fx_valid),
      .gnt_idx    (fx_idx),
      .gnt_onehot (fx_onehot),
      .ptr        (fx_ptr)
   );

   function automatic exp_t mk(input logic v, input int idx, input logic [N-1:0] oh, input int p);
      exp_t e;
      e.v   = v;
      e.idx = IW'(idx);
      e.oh  = oh;
      e.ptr = PW'(p);
      return e;
   endfunction

   function automatic logic [N-1:0] bit_of(input int i);
      logic [N-1:0] one;
      one = N'(1);
      return one << i;
   endfunction

   task automatic compare(input string name, input exp_t e, input logic v, input logic [IW-1:0] idx,
                          input logic [N-1:0] oh, input logic [PW-1:0] p);
      checks++;
      if (v === e.v && idx === e.idx && oh === e.oh && p === e.ptr) begin
         passes++;
         $display("%s txn %0d: valid=%0b idx=%0d onehot=%h ptr=%0d ok", name, checks, v, idx, oh, p);
      end else begin
         $display("FAIL %s txn %0d: got valid=%0b idx=%0d onehot=%h ptr=%0d, expected valid=%0b idx=%0d onehot=%h ptr=%0d",
                  name, checks, v, idx, oh, p, e.v, e.idx, e.oh, e.ptr);
      end
   endtask

   // Monitor: pops expectations one edge after they were queued.
   always @(posedge clk) begin
      #1;
      if (q_rr.size() > 0) compare("rr", q_rr.pop_front(), rr_valid, rr_idx, rr_onehot, rr_ptr);
      if (q_fx.size() > 0) compare("fx", q_fx.pop_front(), fx_valid, fx_idx, fx_onehot, fx_ptr);
   end

   task automatic drive(input logic rn, input logic [N-1:0] r, input logic rdy, input logic lk,
                        input logic chk_rr, input exp_t er, input logic chk_fx, input exp_t ef);
      @(negedge clk);
      rst_n     = rn;
      req       = r;
      gnt_ready = rdy;
      lock      = lk;
      if (chk_rr) q_rr.push_back(er);
      if (chk_fx) q_fx.push_back(ef);
      @(posedge clk);
   endtask

   initial begin
      exp_t z;
      exp_t rst_e;
      z     = '0;
      rst_e = mk(1'b0, 16, '0, 0);

      // Reset with all requests asserted, then first fixed and round-robin loads.
      drive(1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, rst_e, 1'b1, rst_e);
      drive(1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, rst_e, 1'b1, rst_e);
      drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, mk(1'b1, 0, 16'h0001, 0), 1'b1, mk(1'b1, 0, 16'h0001, 0));

      // Fixed priority always picks bit 5 of 0x0120.
      drive(1'b1, 16'h0120, 1'b1, 1'b0, 1'b0, z, 1'b1, mk(1'b1, 5, 16'h0020, 1));
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 16'h0120, 1'b1, 1'b0, 1'b0, z, 1'b1, mk(1'b1, 5, 16'h0020, 6));
      end

      // Fresh reset, then round-robin wrap over all requesters.
      drive(1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, rst_e, 1'b0, z);
      for (int k = 0; k <= 16; k++) begin
         drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, mk(1'b1, k % 16, bit_of(k % 16), k % 16), 1'b0, z);
      end

      // Backpressure: grant 0 stays put while stalled even as req changes.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 16'h0081, 1'b0, 1'b0, 1'b1, mk(1'b1, 0, 16'h0001, 0), 1'b0, z);
      end
      drive(1'b1, 16'h0080, 1'b0, 1'b0, 1'b1, mk(1'b1, 0, 16'h0001, 0), 1'b0, z);
      drive(1'b1, 16'h0080, 1'b1, 1'b0, 1'b1, mk(1'b1, 7, 16'h0080, 1), 1'b0, z);

      // Empty request, top requester, wrap of ptr, ready ignored while idle.
      drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, mk(1'b0, 16, 16'h0000, 8), 1'b0, z);
      drive(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, mk(1'b1, 15, 16'h8000, 8), 1'b0, z);
      drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, mk(1'b0, 16, 16'h0000, 0), 1'b0, z);
      drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, mk(1'b0, 16, 16'h0000, 0), 1'b0, z);

      // Sole requester is regranted; a competitor wins once it appears.
      drive(1'b1, 16'h0008, 1'b1, 1'b0, 1'b1, mk(1'b1, 3, 16'h0008, 0), 1'b0, z);
      drive(1'b1, 16'h0008, 1'b1, 1'b0, 1'b1, mk(1'b1, 3, 16'h0008, 4), 1'b0, z);
      drive(1'b1, 16'h0018, 1'b1, 1'b0, 1'b1, mk(1'b1, 4, 16'h0010, 4), 1'b0, z);

`ifdef RR_IDX_ARBITER_LOCK_EN
      // Lock with req[4] clear arbitrates normally, then holds grant 0.
      drive(1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, mk(1'b1, 0, 16'h0001, 5), 1'b0, z);
      drive(1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, mk(1'b1, 0, 16'h0001, 5), 1'b0, z);
      drive(1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, mk(1'b1, 0, 16'h0001, 5), 1'b0, z);
      drive(1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, mk(1'b1, 1, 16'h0002, 1), 1'b0, z);
`endif

      // Drain with a bounded wait.
      for (int k = 0; k < 10 && (q_rr.size() > 0 || q_fx.size() > 0); k++) begin
         @(negedge clk);
      end
      if (q_rr.size() > 0 || q_fx.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d rr and %0d fx expectations left, required 0", q_rr.size(), q_fx.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
